// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, constants and response-buffer state type for the register read port
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam int ZERO_REG   = 0;

    // Encoding doubles as the buffer occupancy count
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    // A register slot that really stores data: not the hardwired zero and inside the bank
    function automatic logic is_backed(input int addr, input int num_regs);
        return addr != ZERO_REG && addr < num_regs;
    endfunction

endpackage

// File: rtl/resp_fifo2.sv
// resp_fifo2: two-entry in-order response buffer with occupancy state and head output
module resp_fifo2
    import regfile_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    push_data,
    output buf_state_t      state,
    output logic [W-1:0]    head
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;
    buf_state_t   state_next;

    assign do_push = push && state != FULL;
    assign do_pop  = pop && state != EMPTY;

    // Occupancy transitions: simultaneous push and pop leave ONE unchanged
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   state_next = do_push ? ONE : EMPTY;
            ONE:     state_next = do_push == do_pop ? ONE : (do_push ? FULL : EMPTY);
            FULL:    state_next = do_pop ? ONE : FULL;
            default: state_next = EMPTY;
        endcase
    end

    // State register and wrapping one-bit pointers
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            state <= state_next;
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
        end
    end

    // Entry storage; data is fixed once pushed so later register writes cannot touch it
    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = state == EMPTY ? '0 : mem[rd_ptr];

endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port: register bank with one write port and a handshaked, buffered read port
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  rdReqValid,
    output logic                  rdReqReady,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic                  rdRespValid,
    input  logic                  rdRespReady,
    output logic [DATA_WIDTH-1:0] rdRespData
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_hit;
    logic                  rd_backed;
    logic                  accept;
    logic                  release_head;
    logic [DATA_WIDTH-1:0] rd_value;
    buf_state_t            buf_state;

    assign wr_hit       = writeEnable && is_backed(int'(writeAddr), NUM_REGS);
    assign rd_backed    = is_backed(int'(rdAddr), NUM_REGS);
    assign accept       = rdReqValid && rdReqReady;
    assign release_head = rdRespValid && rdRespReady;
    assign rdReqReady   = buf_state != FULL;
    assign rdRespValid  = buf_state != EMPTY;

    // Read mux: zero register and unbacked addresses read 0, same-cycle write is forwarded
    always_comb begin
        rd_value = '0;
        if (rd_backed)
            rd_value = wr_hit && writeAddr == rdAddr ? writeData : regs[rdAddr];
    end

    // Register bank write port
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[writeAddr] <= writeData;
        end
    end

    resp_fifo2 #(
        .W(DATA_WIDTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .pop       (release_head),
        .push_data (rd_value),
        .state     (buf_state),
        .head      (rdRespData)
    );

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read-side responder for the CPU's 32-bit register storage, the counterpart to the write-enabled register write path.
- Holds a bank of NUM_REGS registers with one write port (writeEnable/address/data) and one handshaked read port.
- A read is accepted with a valid/ready request; its data returns one cycle later through a 2-entry response buffer, so the decode/execute stage can stall the response side without losing reads.

Parameters:
- DATA_WIDTH, 32, width of each register and of read/write data.
- ADDR_WIDTH, 5, width of read and write addresses.
- NUM_REGS, 32, number of implemented registers (<= 2**ADDR_WIDTH).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clock.
- writeEnable  input  1  write strobe for the register bank.
- writeAddr  input  ADDR_WIDTH  register written when writeEnable=1.
- writeData  input  DATA_WIDTH  value written.
- rdReqValid  input  1  read request present.
- rdReqReady  output  1  block can accept a read request this cycle.
- rdAddr  input  ADDR_WIDTH  register to read; sampled on acceptance.
- rdRespValid  output  1  rdRespData holds a valid response.
- rdRespReady  input  1  consumer takes the response this cycle.
- rdRespData  output  DATA_WIDTH  read data, head of response buffer.

Behaviour:
- Reset (synchronous, active-high; has priority over every other event in that cycle): all registers cleared to 0; response buffer flushed (count=0). Outputs next cycle: rdRespValid=0, rdRespData=0, rdReqReady=1.
- Register 0 always reads 0. Writes to address 0 are ignored. Address >= NUM_REGS reads 0, and writes to it are ignored.
- Write: on posedge with writeEnable=1 and a legal non-zero address, reg[writeAddr] <= writeData.
- Request accepted on a posedge where rdReqValid && rdReqReady. Data is captured into the response buffer at that edge, and rdRespValid is 1 from the next cycle. Latency is exactly 1 cycle when the buffer was empty.
- Forwarding: if the accepted read hits the same legal non-zero address being written in the same cycle, the captured data is writeData (new value).
- Snapshot semantics: data is fixed at acceptance. Later writes never alter queued responses.
- Response buffer: 2-entry FIFO, in-order. Buffer state is EMPTY (count 0), ONE (count 1) or FULL (count 2).
  - Push = request accepted. Pop = rdRespValid && rdRespReady.
  - EMPTY: push -> ONE; otherwise stay.
  - ONE: push and pop -> ONE; push only -> FULL; pop only -> EMPTY.
  - FULL: pop -> ONE; no push is possible.
- rdReqReady = (count != 2). It depends only on registered state, never combinationally on rdRespReady.
- rdRespValid = (count != 0). rdRespData = head entry when valid, 0 when empty.
- Response outputs must stay stable while rdRespValid=1 and rdRespReady=0.
- Reset mid-operation discards queued responses. There is no partial completion.
- Arithmetic: the count is a 2-bit saturating-by-construction counter. Read and write pointers are 1 bit each and wrap naturally.

Decomposition:
- Package regfile_pkg: DATA_WIDTH/ADDR_WIDTH/NUM_REGS defaults, ZERO_REG constant (0), and a typedef for the buffer-state enum {EMPTY, ONE, FULL}.
- One sub-module, resp_fifo2: the 2-entry response FIFO with push/pop, count, and head output. The top level holds the register array, write logic, forwarding mux and address decode.

Test Plan:
- Reset then read addr 5 with rdRespReady=1 -> rdRespValid=1 one cycle after acceptance, rdRespData=0x00000000.
- Write 0xDEADBEEF to reg 7, next cycle read 7 -> response 0xDEADBEEF. Write 0x12345678 to reg 0, read 0 -> 0x00000000.
- Same cycle: write 0xCAFEF00D to reg 9 and accept read 9 -> response 0xCAFEF00D (forwarded).
- Hold rdRespReady=0 and issue reads of reg 1 (0x11) and reg 2 (0x22) -> rdReqReady=0 after the second acceptance, data stays 0x11. Then release: 0x11 then 0x22 on consecutive cycles, and rdReqReady returns 1.
- Queue a read of reg 3 (0x33) with the consumer stalled, then write reg 3 = 0x99 -> dequeued response is 0x33.
- Two responses queued, assert reset for one cycle -> next cycle rdRespValid=0, rdReqReady=1, and a subsequent read of any register returns 0.
